// File: rtl/topk_argmax_if.sv
// topk_argmax_if: request/result bundle for the top-K selector.
//   start, find_min, vec     : scan request (vec held stable for the whole scan)
//   topk_idx, topk_val       : published results, best first
//   busy, done               : scan in progress / one-cycle result-update pulse
// master = requester side, slave = selector side.
interface topk_argmax_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 10,
    parameter int K          = 3,
    parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM)
);
    logic                                start;
    logic                                find_min;
    logic [0:DIM-1][DATA_WIDTH-1:0]      vec;
    logic [0:K-1][IDXW-1:0]              topk_idx;
    logic [0:K-1][DATA_WIDTH-1:0]        topk_val;
    logic                                busy;
    logic                                done;

    modport master (
        output start, find_min, vec,
        input  topk_idx, topk_val, busy, done
    );

    modport slave (
        input  start, find_min, vec,
        output topk_idx, topk_val, busy, done
    );
endinterface

// File: rtl/topk_argmax.sv
// topk_argmax: scans a DIM-element signed vector one element per cycle and
// keeps a best-first list of the K largest (or smallest) entries.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : topk_argmax_if.slave (start/find_min/vec in; topk_idx/topk_val/busy/done out)
// Results and done are registered; they change only on the FINISH edge.

// One working-list slot. Decides whether the current element beats this
// slot's entry and what the slot holds after the insertion.
module topk_argmax_slot #(
    parameter int DW   = 16,
    parameter int IDXW = 4
) (
    input  logic [DW-1:0]   cur_val,
    input  logic [IDXW-1:0] cur_idx,
    input  logic            find_min,
    input  logic            vld,
    input  logic [DW-1:0]   val,
    input  logic [IDXW-1:0] idx,
    input  logic            prev_vld,
    input  logic [DW-1:0]   prev_val,
    input  logic [IDXW-1:0] prev_idx,
    input  logic            hit_before,   // insertion point lies above this slot
    output logic            take,
    output logic            nxt_vld,
    output logic [DW-1:0]   nxt_val,
    output logic [IDXW-1:0] nxt_idx
);
    logic better;

    // Strict compare: an equal value never displaces an earlier entry.
    assign better = find_min ? ($signed(cur_val) < $signed(val))
                             : ($signed(cur_val) > $signed(val));
    assign take   = !vld || better;

    always_comb begin
        nxt_vld = vld;
        nxt_val = val;
        nxt_idx = idx;
        if (hit_before) begin
            // Shift down from the slot above; the last slot's entry falls off.
            nxt_vld = prev_vld;
            nxt_val = prev_val;
            nxt_idx = prev_idx;
        end else if (take) begin
            nxt_vld = 1'b1;
            nxt_val = cur_val;
            nxt_idx = cur_idx;
        end
    end
endmodule

module topk_argmax #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 10,
    parameter int K          = 3,
    parameter int IDXW       = (DIM <= 1) ? 1 : $clog2(DIM)
) (
    input  logic          clk,
    input  logic          reset,
    topk_argmax_if.slave  bus
);
    localparam int CW = IDXW + 1;

    if (DIM < 1 || K < 1 || K > DIM) begin : g_bad_params
        $error("topk_argmax: need DIM >= 1 and 1 <= K <= DIM");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_e;

    state_e                          state_q, state_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            mode_q, mode_d;
    logic [K-1:0]                    wvld_q, wvld_d;
    logic [0:K-1][DATA_WIDTH-1:0]    wval_q, wval_d;
    logic [0:K-1][IDXW-1:0]          widx_q, widx_d;
    logic [0:K-1][DATA_WIDTH-1:0]    oval_q, oval_d;
    logic [0:K-1][IDXW-1:0]          oidx_q, oidx_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic [DATA_WIDTH-1:0]           cur_val;
    logic [IDXW-1:0]                 cur_idx;
    logic [K-1:0]                    take, hit, nxt_vld;
    logic [0:K-1][DATA_WIDTH-1:0]    nxt_val;
    logic [0:K-1][IDXW-1:0]          nxt_idx;

    assign cur_idx = cnt_q[IDXW-1:0];
    assign cur_val = bus.vec[cur_idx];

    // hit[j]: some slot above j already accepts the element, so j shifts.
    for (genvar j = 0; j < K; j++) begin : g_slot
        if (j == 0) begin : g_first
            assign hit[j] = 1'b0;
        end else begin : g_rest
            assign hit[j] = hit[j-1] | take[j-1];
        end

        topk_argmax_slot #(.DW(DATA_WIDTH), .IDXW(IDXW)) u_slot (
            .cur_val    (cur_val),
            .cur_idx    (cur_idx),
            .find_min   (mode_q),
            .vld        (wvld_q[j]),
            .val        (wval_q[j]),
            .idx        (widx_q[j]),
            .prev_vld   (wvld_q[(j == 0) ? 0 : j-1]),
            .prev_val   (wval_q[(j == 0) ? 0 : j-1]),
            .prev_idx   (widx_q[(j == 0) ? 0 : j-1]),
            .hit_before (hit[j]),
            .take       (take[j]),
            .nxt_vld    (nxt_vld[j]),
            .nxt_val    (nxt_val[j]),
            .nxt_idx    (nxt_idx[j])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        wvld_d  = wvld_q;
        wval_d  = wval_q;
        widx_d  = widx_q;
        oval_d  = oval_q;
        oidx_d  = oidx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d  = bus.find_min;
                    wvld_d  = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wvld_d = nxt_vld;
                wval_d = nxt_val;
                widx_d = nxt_idx;
                if (cnt_q == CW'(DIM - 1)) state_d = S_FINISH;
                else                       cnt_d   = cnt_q + 1'b1;
            end
            S_FINISH: begin
                oval_d  = wval_q;
                oidx_d  = widx_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            wvld_q  <= '0;
            wval_q  <= '0;
            widx_q  <= '0;
            oval_q  <= '0;
            oidx_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            wvld_q  <= wvld_d;
            wval_q  <= wval_d;
            widx_q  <= widx_d;
            oval_q  <= oval_d;
            oidx_q  <= oidx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.topk_idx = oidx_q;
    assign bus.topk_val = oval_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_topk_argmax.sv
// Bench for topk_argmax: a K=3 and a K=1 instance share one stimulus stream.
// Expected results come from a selection-sort reference (repeatedly pick the
// best unused element, lowest index on ties).
module tb_topk_argmax;
    localparam int DW   = 16;
    localparam int DIM  = 10;
    localparam int K    = 3;
    localparam int IDXW = $clog2(DIM);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    topk_argmax_if #(.DATA_WIDTH(DW), .DIM(DIM), .K(K), .IDXW(IDXW)) b3 ();
    topk_argmax_if #(.DATA_WIDTH(DW), .DIM(DIM), .K(1), .IDXW(IDXW)) b1 ();

    assign b1.start    = b3.start;
    assign b1.find_min = b3.find_min;
    assign b1.vec      = b3.vec;

    topk_argmax #(.DATA_WIDTH(DW), .DIM(DIM), .K(K), .IDXW(IDXW)) dut3 (
        .clk(clk), .reset(reset), .bus(b3));
    topk_argmax #(.DATA_WIDTH(DW), .DIM(DIM), .K(1), .IDXW(IDXW)) dut1 (
        .clk(clk), .reset(reset), .bus(b1));

    int checks   = 0;
    int failures = 0;
    int vv[DIM];
    int exp_idx[K];
    int exp_val[K];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_vec();
        for (int j = 0; j < DIM; j++) b3.vec[j] = vv[j][DW-1:0];
    endtask

    function automatic bit better(input int a, input int b, input bit fm);
        return fm ? (a < b) : (a > b);
    endfunction

    task automatic model(input bit fm);
        bit used[DIM];
        int best;
        for (int j = 0; j < DIM; j++) used[j] = 1'b0;
        for (int k = 0; k < K; k++) begin
            best = -1;
            for (int j = 0; j < DIM; j++)
                if (!used[j] && (best < 0 || better(vv[j], vv[best], fm))) best = j;
            used[best] = 1'b1;
            exp_idx[k] = best;
            exp_val[k] = vv[best];
        end
    endtask

    task automatic check_results(input string tag);
        for (int k = 0; k < K; k++) begin
            check($sformatf("%s_idx%0d", tag, k), int'(b3.topk_idx[k]), exp_idx[k]);
            check($sformatf("%s_val%0d", tag, k), int'($signed(b3.topk_val[k])), exp_val[k]);
        end
        check({tag, "_k1_idx"}, int'(b1.topk_idx[0]), exp_idx[0]);
        check({tag, "_k1_val"}, int'($signed(b1.topk_val[0])), exp_val[0]);
    endtask

    task automatic check_flags(input string tag, input int busy, input int done);
        check({tag, "_busy"},    int'(b3.busy), busy);
        check({tag, "_done"},    int'(b3.done), done);
        check({tag, "_k1_busy"}, int'(b1.busy), busy);
        check({tag, "_k1_done"}, int'(b1.done), done);
    endtask

    task automatic check_zero(input string tag);
        check_flags(tag, 0, 0);
        for (int k = 0; k < K; k++) begin
            check($sformatf("%s_idx%0d", tag, k), int'(b3.topk_idx[k]), 0);
            check($sformatf("%s_val%0d", tag, k), int'(b3.topk_val[k]), 0);
        end
        check({tag, "_k1_idx"}, int'(b1.topk_idx[0]), 0);
        check({tag, "_k1_val"}, int'(b1.topk_val[0]), 0);
    endtask

    // One full scan from IDLE; optionally flips find_min every RUN cycle.
    task automatic run_scan(input string tag, input bit fm, input bit toggle);
        model(fm);
        load_vec();
        b3.find_min = fm;
        b3.start    = 1'b1;
        tick();                                   // edge E
        b3.start = 1'b0;
        check_flags({tag, "_e0"}, 1, 0);
        for (int c = 1; c <= DIM; c++) begin      // edges E+1 .. E+DIM
            if (toggle) b3.find_min = ~b3.find_min;
            tick();
            check_flags($sformatf("%s_e%0d", tag, c), 1, 0);
        end
        tick();                                   // edge E+DIM+1
        check_flags({tag, "_fin"}, 0, 1);
        check_results({tag, "_res"});
        tick();
        check_flags({tag, "_post"}, 0, 0);
        check_results({tag, "_hold"});
    endtask

    initial begin
        int ci[K];
        int cv[K];
        bit exp_busy, exp_done;

        reset       = 1'b1;
        b3.start    = 1'b0;
        b3.find_min = 1'b0;
        b3.vec      = '0;
        tick();
        tick();
        check_zero("rst");
        reset = 1'b0;
        tick();
        check_zero("idle");

        // Directed max mode with a three-way tie at value 9.
        vv = '{5, -3, 9, 9, 0, 7, -8, 2, 9, 1};
        run_scan("max", 1'b0, 1'b0);
        ci = '{2, 3, 8};
        for (int k = 0; k < K; k++) begin
            check($sformatf("max_const_idx%0d", k), int'(b3.topk_idx[k]), ci[k]);
            check($sformatf("max_const_val%0d", k), int'($signed(b3.topk_val[k])), 9);
        end

        // Same vector, min mode.
        run_scan("min", 1'b1, 1'b0);
        ci = '{6, 1, 4};
        cv = '{-8, -3, 0};
        for (int k = 0; k < K; k++) begin
            check($sformatf("min_const_idx%0d", k), int'(b3.topk_idx[k]), ci[k]);
            check($sformatf("min_const_val%0d", k), int'($signed(b3.topk_val[k])), cv[k]);
        end

        // All equal at the most-negative value.
        for (int j = 0; j < DIM; j++) vv[j] = -32768;
        run_scan("alleq", 1'b0, 1'b0);
        for (int k = 0; k < K; k++)
            check($sformatf("alleq_const_idx%0d", k), int'(b3.topk_idx[k]), k);

        // Single most-positive value among most-negative ones.
        vv[5] = 32767;
        run_scan("extreme", 1'b0, 1'b0);
        check("extreme_const_idx0", int'(b3.topk_idx[0]), 5);
        check("extreme_const_val0", int'($signed(b3.topk_val[0])), 32767);

        // K=1 argmax with first-index tie-break.
        vv = '{1, 4, 4, 2, 0, -1, 3, 4, 1, 0};
        run_scan("argmax", 1'b0, 1'b0);
        check("argmax_k1_const_idx", int'(b1.topk_idx[0]), 1);

        // Start ignored while busy; accepted in the done cycle, giving
        // back-to-back scans DIM+2 edges apart (second done at E+23).
        for (int j = 0; j < DIM; j++) vv[j] = int'($urandom_range(0, 65535)) - 32768;
        model(1'b0);
        load_vec();
        b3.find_min = 1'b0;
        b3.start    = 1'b1;
        tick();                                   // edge E
        b3.start = 1'b0;
        check_flags("b2b_t0", 1, 0);
        for (int t = 1; t <= 23; t++) begin
            b3.start    = (t == 3 || t == 10 || t == 12);
            b3.find_min = (t == 3 || t == 10 || t == 12);
            if (t == 12) begin
                for (int j = 0; j < DIM; j++) vv[j] = int'($urandom_range(0, 6)) - 3;
                model(1'b1);
                load_vec();
            end
            tick();
            exp_done = (t == 11 || t == 23);
            exp_busy = (t <= 10) || (t >= 12 && t <= 22);
            check_flags($sformatf("b2b_t%0d", t), int'(exp_busy), int'(exp_done));
            if (t == 11) check_results("b2b_first");
            b3.start = 1'b0;
        end
        check_results("b2b_second");
        tick();
        check_flags("b2b_after", 0, 0);

        // Reset mid-scan: no done, outputs cleared.
        for (int j = 0; j < DIM; j++) vv[j] = int'($urandom_range(0, 65535)) - 32768;
        load_vec();
        b3.start = 1'b1;
        tick();                                   // edge E
        b3.start = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        reset = 1'b1;
        tick();                                   // edge E+5
        check_zero("midrst");
        reset = 1'b0;
        for (int c = 0; c < DIM + 2; c++) begin
            tick();
            check_flags($sformatf("midrst_quiet%0d", c), 0, 0);
        end

        // Fresh scan after reset with find_min toggled during RUN.
        for (int j = 0; j < DIM; j++) vv[j] = int'($urandom_range(0, 65535)) - 32768;
        run_scan("toggle_max", 1'b0, 1'b1);
        for (int j = 0; j < DIM; j++) vv[j] = int'($urandom_range(0, 65535)) - 32768;
        run_scan("toggle_min", 1'b1, 1'b1);

        // Random scans: full range, narrow range (many ties), and extremes.
        for (int r = 0; r < 24; r++) begin
            for (int j = 0; j < DIM; j++) begin
                case (r % 3)
                    0: vv[j] = int'($urandom_range(0, 65535)) - 32768;
                    1: vv[j] = int'($urandom_range(0, 6)) - 3;
                    default: vv[j] = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
                endcase
            end
            run_scan($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
